// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width, FSM state
// encoding and the nibble data type.
package adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef logic [NIBBLE_W-1:0] nibble_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } serial_add_state_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Request/result bundle between a requesting datapath (master) and the
// nibble-serial adder (slave). The sub signal exists only when
// SERIAL_ADD_SUB_EN is defined.
interface nibble_serial_adder_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;

`ifdef SERIAL_ADD_SUB_EN
  modport master (output start, a, b, c_in, sub, input busy, done, sum, c_out);
  modport slave  (input start, a, b, c_in, sub, output busy, done, sum, c_out);
`else
  modport master (output start, a, b, c_in, input busy, done, sum, c_out);
  modport slave  (input start, a, b, c_in, output busy, done, sum, c_out);
`endif

endinterface

// File: rtl/nibble_serial_adder_add4_cell.sv
// Combinational 4-bit ripple-carry adder cell built from gate-level full
// adders. Shared by all nibbles of the serial adder.
import adder_pkg::*;

module add4_cell (
  output nibble_t sum_o,
  output logic    co_o,
  input  nibble_t a_i,
  input  nibble_t b_i,
  input  logic    ci_i
);
  wire [3:0] p_w;
  wire [3:0] s_w;
  wire [3:0] g_w;
  wire [3:0] t_w;
  wire [4:0] c_w;

  assign c_w[0] = ci_i;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    xor u_p (p_w[i], a_i[i], b_i[i]);
    xor u_s (s_w[i], p_w[i], c_w[i]);
    and u_g (g_w[i], a_i[i], b_i[i]);
    and u_t (t_w[i], p_w[i], c_w[i]);
    or  u_c (c_w[i+1], g_w[i], t_w[i]);
  end

  assign sum_o = s_w;
  assign co_o  = c_w[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: sequences one 4-bit adder cell over NIBBLES nibbles,
// LSB nibble first, with a registered carry between nibbles.
// Optional feature macro: SERIAL_ADD_SUB_EN (adds subtract mode via bus.sub).
import adder_pkg::*;

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input logic                   clk,
  input logic                   reset,
  nibble_serial_adder_if.slave  bus
);
  localparam int         W        = NIBBLE_W * NIBBLES;
  localparam logic [3:0] LAST_IDX = 4'(NIBBLES - 1);

  serial_add_state_t state_q, state_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [W-1:0]      sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              c_out_q, c_out_d;
  logic [3:0]        idx_q, idx_d;
  logic              accept;

  nibble_t cell_a;
  nibble_t cell_b;
  nibble_t cell_sum;
  logic    cell_co;

  // The index register selects which captured nibble feeds the single cell.
  assign cell_a = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
  assign cell_b = b_q[NIBBLE_W*idx_q +: NIBBLE_W];

  add4_cell u_cell (
    .sum_o (cell_sum),
    .co_o  (cell_co),
    .a_i   (cell_a),
    .b_i   (cell_b),
    .ci_i  (carry_q)
  );

  // Next-state: accept in IDLE/DONE, ripple one nibble per cycle in RUN.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    idx_d   = idx_q;
    accept  = bus.start && (state_q != RUN);

    case (state_q)
      RUN: begin
        sum_d[NIBBLE_W*idx_q +: NIBBLE_W] = cell_sum;
        carry_d = cell_co;
        idx_d   = idx_q + 4'd1;
        if (idx_q == LAST_IDX) begin
          c_out_d = cell_co;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      a_d     = bus.a;
      idx_d   = 4'd0;
      state_d = RUN;
`ifdef SERIAL_ADD_SUB_EN
      // Subtraction is A + ~B + 1; the caller's carry-in is ignored.
      if (bus.sub) begin
        b_d     = ~bus.b;
        carry_d = 1'b1;
      end else begin
        b_d     = bus.b;
        carry_d = bus.c_in;
      end
`else
      b_d     = bus.b;
      carry_d = bus.c_in;
`endif
    end
  end

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      idx_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder with NIBBLES=4.
module tb_nibble_serial_adder;
  localparam int NIB = 4;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_if #(.NIBBLES(NIB)) bus ();

  nibble_serial_adder #(.NIBBLES(NIB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic cin);
    bus.a     = av;
    bus.b     = bv;
    bus.c_in  = cin;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub   = 1'b0;
`endif
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL rst_done got %b want 0", bus.done); end
    tests++; if (bus.sum !== 16'h0000) begin fails++; $display("FAIL rst_sum got %h want 0000", bus.sum); end
    tests++; if (bus.c_out !== 1'b0) begin fails++; $display("FAIL rst_cout got %b want 0", bus.c_out); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop;
    int lat;
    issue(16'h1234, 16'h1111, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++; if (bus.sum !== 16'h0045) begin fails++; $display("FAIL midop_partial got %h want 0045", bus.sum); end
    reset = 1'b1;
    #1;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midop_busy got %b want 0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL midop_done got %b want 0", bus.done); end
    tests++; if (bus.sum !== 16'h0000) begin fails++; $display("FAIL midop_sum got %h want 0000", bus.sum); end
    tests++; if (bus.c_out !== 1'b0) begin fails++; $display("FAIL midop_cout got %b want 0", bus.c_out); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midop_idle got busy %b want 0", bus.busy); end
    issue(16'h0003, 16'h0004, 1'b0);
    wait_done(lat);
    tests++; if (lat !== 4) begin fails++; $display("FAIL midop_after_lat got %0d want 4", lat); end
    tests++; if (bus.sum !== 16'h0007) begin fails++; $display("FAIL midop_after_sum got %h want 0007", bus.sum); end
  endtask

  task automatic test_basic;
    int lat;
    issue(16'h0003, 16'h0004, 1'b0);
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL basic_busy got %b want 1", bus.busy); end
    bus.a = 16'hAAAA; bus.b = 16'h5555; bus.c_in = 1'b1;
    wait_done(lat);
    tests++; if (lat !== 4) begin fails++; $display("FAIL basic_lat got %0d want 4", lat); end
    tests++; if (bus.sum !== 16'h0007) begin fails++; $display("FAIL basic_sum got %h want 0007", bus.sum); end
    tests++; if (bus.c_out !== 1'b0) begin fails++; $display("FAIL basic_cout got %b want 0", bus.c_out); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL basic_busy_done got %b want 0", bus.busy); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL basic_done_pulse got %b want 0", bus.done); end
    tests++; if (bus.sum !== 16'h0007) begin fails++; $display("FAIL basic_hold got %h want 0007", bus.sum); end
  endtask

  task automatic test_ripple;
    int lat;
    issue(16'hFFFF, 16'h0001, 1'b0);
    wait_done(lat);
    tests++; if (lat !== 4) begin fails++; $display("FAIL ripple_lat got %0d want 4", lat); end
    tests++; if (bus.sum !== 16'h0000) begin fails++; $display("FAIL ripple_sum got %h want 0000", bus.sum); end
    tests++; if (bus.c_out !== 1'b1) begin fails++; $display("FAIL ripple_cout got %b want 1", bus.c_out); end
  endtask

  task automatic test_carry_in;
    int lat;
    issue(16'h0F0F, 16'h00F1, 1'b1);
    wait_done(lat);
    tests++; if (bus.sum !== 16'h1001) begin fails++; $display("FAIL cin_sum got %h want 1001", bus.sum); end
    tests++; if (bus.c_out !== 1'b0) begin fails++; $display("FAIL cin_cout got %b want 0", bus.c_out); end
  endtask

  task automatic test_ignore_busy;
    int   lat;
    logic seen;
    issue(16'h0100, 16'h0200, 1'b0);
    @(posedge clk); #1;
    bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(lat);
    tests++; if (lat !== 2) begin fails++; $display("FAIL ignore_lat got %0d want 2", lat); end
    tests++; if (bus.sum !== 16'h0300) begin fails++; $display("FAIL ignore_sum got %h want 0300", bus.sum); end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen = 1'b1;
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL ignore_extra_op got %b want 0", seen); end
  endtask

  task automatic test_back_to_back;
    int lat1;
    int lat2;
    bus.a = 16'h0001; bus.b = 16'h0002; bus.c_in = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub = 1'b0;
`endif
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.a = 16'h1234; bus.b = 16'h1111;
    wait_done(lat1);
    tests++; if (lat1 !== 4) begin fails++; $display("FAIL b2b_lat1 got %0d want 4", lat1); end
    tests++; if (bus.sum !== 16'h0003) begin fails++; $display("FAIL b2b_sum1 got %h want 0003", bus.sum); end
    @(posedge clk); #1;
    bus.start = 1'b0;
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL b2b_busy got %b want 1", bus.busy); end
    wait_done(lat2);
    if (lat2 >= 0) lat2 = lat2 + 1;
    tests++; if (lat2 !== 5) begin fails++; $display("FAIL b2b_gap got %0d want 5", lat2); end
    tests++; if (bus.sum !== 16'h2345) begin fails++; $display("FAIL b2b_sum2 got %h want 2345", bus.sum); end
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub;
    int lat;
    bus.a = 16'h0005; bus.b = 16'h0007; bus.c_in = 1'b0; bus.sub = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.sub = 1'b0;
    wait_done(lat);
    tests++; if (bus.sum !== 16'hFFFE) begin fails++; $display("FAIL sub_neg_sum got %h want fffe", bus.sum); end
    tests++; if (bus.c_out !== 1'b0) begin fails++; $display("FAIL sub_neg_cout got %b want 0", bus.c_out); end
    bus.a = 16'h0007; bus.b = 16'h0005; bus.c_in = 1'b0; bus.sub = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.sub = 1'b0;
    wait_done(lat);
    tests++; if (bus.sum !== 16'h0002) begin fails++; $display("FAIL sub_pos_sum got %h want 0002", bus.sum); end
    tests++; if (bus.c_out !== 1'b1) begin fails++; $display("FAIL sub_pos_cout got %b want 1", bus.c_out); end
  endtask
`endif

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.c_in  = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub   = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_reset_midop();
    test_basic();
    test_ripple();
    test_carry_in();
    test_ignore_busy();
    test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
